// File: rtl/detect_n_bit_sequence_using_fsm.sv
// -----------------------------------------------------------------------------
// detect_n_bit_sequence_using_fsm
//
// Serial pattern detector with a run-time programmable pattern of 0..MAX_LEN
// bits. Bits arrive on `a` when `a_vld` is high and are shifted into a history
// register. Once enough valid bits have been collected, the newest `len` bits
// are compared against the stored pattern on every valid cycle. A match raises
// a one-cycle registered pulse on `detected` and bumps a saturating counter.
// Overlapping or non-overlapping detection is selected at configuration time.
//
// Parameters:
//   MAX_LEN      maximum pattern length in bits (2..32)
//   CNT_W        width of the match counter
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   a            serial data bit
//   a_vld        qualifies `a` for this cycle
//   cfg_load     one-cycle strobe: capture cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  pattern; bit [len-1] is expected first, bit [0] last
//   cfg_len      pattern length (values above MAX_LEN are clamped)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   detected     registered one-cycle match pulse
//   match_cnt    saturating number of matches since reset or last load
// -----------------------------------------------------------------------------
module detect_n_bit_sequence_using_fsm #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               a_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detected,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               detected_q;
    logic [CNT_W-1:0]   cnt_q;

    // Next-value helpers shared by the FSM below.
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] mask_d;
    logic               hit_d;
    logic [LEN_W-1:0]   len_d;
    logic [LEN_W-1:0]   fill_d;
    logic [CNT_W-1:0]   cnt_d;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], a};

        // Only the newest len_q bits take part in the comparison.
        mask_d = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                mask_d[i] = 1'b1;
            end
        end

        // The window includes the bit being sampled this cycle.
        hit_d  = ((hist_d ^ pat_q) & mask_d) == '0;

        len_d  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        fill_d = fill_q + LEN_W'(1);
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            ovl_q      <= 1'b1;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // Match pulse lasts a single cycle unless re-asserted below.
            detected_q <= 1'b0;

            if (cfg_load) begin
                // Load wins over a simultaneous valid bit: that bit is dropped.
                pat_q   <= cfg_pattern;
                len_q   <= len_d;
                ovl_q   <= cfg_overlap;
                hist_q  <= '0;
                fill_q  <= '0;
                cnt_q   <= '0;
                state_q <= (len_d == '0) ? IDLE : FILL;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Zero-length pattern: input is ignored entirely.
                    end

                    FILL: begin
                        if (a_vld) begin
                            hist_q <= hist_d;
                            // The bit completing the window is compared at once,
                            // so the first pulse follows the len-th bit.
                            if (fill_d == len_q && hit_d) begin
                                detected_q <= 1'b1;
                                cnt_q      <= cnt_d;
                                if (ovl_q) begin
                                    fill_q  <= fill_d;
                                    state_q <= ARMED;
                                end else begin
                                    fill_q  <= '0;
                                end
                            end else begin
                                fill_q <= fill_d;
                                if (fill_d == len_q) begin
                                    state_q <= ARMED;
                                end
                            end
                        end
                    end

                    ARMED: begin
                        if (a_vld) begin
                            hist_q <= hist_d;
                            if (hit_d) begin
                                detected_q <= 1'b1;
                                cnt_q      <= cnt_d;
                                // Non-overlap: next match needs len fresh bits.
                                if (!ovl_q) begin
                                    fill_q  <= '0;
                                    state_q <= FILL;
                                end
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign detected  = detected_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_detect_n_bit_sequence_using_fsm.sv
// -----------------------------------------------------------------------------
// tb_detect_n_bit_sequence_using_fsm
//
// Directed bench for detect_n_bit_sequence_using_fsm. Two instances share all
// inputs: the default configuration and one with a 2-bit match counter for the
// saturation scenario. Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge that registers them.
// -----------------------------------------------------------------------------
module tb_detect_n_bit_sequence_using_fsm;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk         = 1'b0;
    logic               rst         = 1'b1;
    logic               a           = 1'b0;
    logic               a_vld       = 1'b0;
    logic               cfg_load    = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len     = '0;
    logic               cfg_overlap = 1'b0;

    logic               detected;
    logic [CNT_W-1:0]   match_cnt;
    logic               detected_s;
    logic [1:0]         match_cnt_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    detect_n_bit_sequence_using_fsm #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .a_vld       (a_vld),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .detected    (detected),
        .match_cnt   (match_cnt)
    );

    detect_n_bit_sequence_using_fsm #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (2)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .a_vld       (a_vld),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .detected    (detected_s),
        .match_cnt   (match_cnt_s)
    );

    // One clock of serial input; returns just after the registering edge.
    task automatic step(input logic b, input logic v);
        @(negedge clk);
        cfg_load = 1'b0;
        a        = b;
        a_vld    = v;
        @(posedge clk);
        #1;
    endtask

    // One configuration cycle, optionally with a simultaneous valid bit.
    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl, input logic b, input logic v);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        a           = b;
        a_vld       = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL reset_det got=%b exp=0", detected);
        end
        checks++;
        if (match_cnt !== '0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", match_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        // Length 0 after reset: valid bits must never produce a pulse.
        for (int i = 0; i < 4; i++) begin
            step(1'(i % 2), 1'b1);
            checks++;
            if (detected !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_det bit=%0d got=%b exp=0", i + 1, detected);
            end
        end
    endtask

    task automatic test_overlap();
        logic [7:0] stream = 8'b0101_0101;
        logic [7:0] exp    = 8'b0001_0101;
        load_cfg(8'b0000_0101, LEN_W'(4), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(stream[7-i], 1'b1);
            checks++;
            if (detected !== exp[7-i]) begin
                failures++;
                $display("FAIL overlap_det bit=%0d got=%b exp=%b", i + 1, detected, exp[7-i]);
            end
        end
        checks++;
        if (match_cnt !== CNT_W'(3)) begin
            failures++;
            $display("FAIL overlap_cnt got=%0d exp=3", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [7:0] stream = 8'b0101_0101;
        logic [7:0] exp    = 8'b0001_0001;
        load_cfg(8'b0000_0101, LEN_W'(4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(stream[7-i], 1'b1);
            checks++;
            if (detected !== exp[7-i]) begin
                failures++;
                $display("FAIL nonoverlap_det bit=%0d got=%b exp=%b", i + 1, detected, exp[7-i]);
            end
        end
        checks++;
        if (match_cnt !== CNT_W'(2)) begin
            failures++;
            $display("FAIL nonoverlap_cnt got=%0d exp=2", match_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [5:0] pat6 = 6'b110011;
        load_cfg(8'b0011_0011, LEN_W'(6), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(pat6[5-k], 1'b1);
            checks++;
            if (detected !== (k == 5)) begin
                failures++;
                $display("FAIL gaps_valid_det bit=%0d got=%b exp=%b", k + 1, detected, (k == 5));
            end
            // Junk on `a` while invalid must be ignored.
            step(~pat6[5-k], 1'b0);
            checks++;
            if (detected !== 1'b0) begin
                failures++;
                $display("FAIL gaps_invalid_det after_bit=%0d got=%b exp=0", k + 1, detected);
            end
        end
        checks++;
        if (match_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL gaps_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_load_priority();
        logic [4:0] stream = 5'b00100;
        logic [4:0] exp    = 5'b00001;
        // Old pattern 0101, leave 0,1,0 in history; a valid 1 would complete it.
        load_cfg(8'b0000_0101, LEN_W'(4), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        load_cfg(8'b0000_0100, LEN_W'(3), 1'b1, 1'b1, 1'b1);
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL loadprio_load_det got=%b exp=0", detected);
        end
        checks++;
        if (match_cnt !== '0) begin
            failures++;
            $display("FAIL loadprio_load_cnt got=%0d exp=0", match_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            step(stream[4-i], 1'b1);
            checks++;
            if (detected !== exp[4-i]) begin
                failures++;
                $display("FAIL loadprio_det bit=%0d got=%b exp=%b", i + 1, detected, exp[4-i]);
            end
        end
        checks++;
        if (match_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL loadprio_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_len1_saturate();
        logic [1:0] exp_s;
        load_cfg(8'b0000_0001, LEN_W'(1), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            exp_s = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (detected_s !== 1'b1 || detected !== 1'b1) begin
                failures++;
                $display("FAIL len1_det bit=%0d got=%b/%b exp=1/1", i + 1, detected, detected_s);
            end
            checks++;
            if (match_cnt_s !== exp_s) begin
                failures++;
                $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", i + 1, match_cnt_s, exp_s);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL len1_zero_det got=%b exp=0", detected);
        end
        checks++;
        if (match_cnt !== CNT_W'(6)) begin
            failures++;
            $display("FAIL len1_cnt got=%0d exp=6", match_cnt);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] stream = 8'b1011_0010;
        load_cfg(8'b1011_0010, LEN_W'(15), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(stream[7-i], 1'b1);
            checks++;
            if (detected !== (i == 7)) begin
                failures++;
                $display("FAIL clamp_det bit=%0d got=%b exp=%b", i + 1, detected, (i == 7));
            end
        end
    endtask

    task automatic test_len0();
        load_cfg(8'h00, LEN_W'(0), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (detected !== 1'b0) begin
                failures++;
                $display("FAIL len0_det bit=%0d got=%b exp=0", i + 1, detected);
            end
        end
        checks++;
        if (match_cnt !== '0) begin
            failures++;
            $display("FAIL len0_cnt got=%0d exp=0", match_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] stream = 4'b0101;
        load_cfg(8'b0000_0101, LEN_W'(4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(stream[3-i], 1'b1);
        end
        checks++;
        if (detected !== 1'b1 || match_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL midrst_pre det=%b cnt=%0d exp det=1 cnt=1", detected, match_cnt);
        end
        // Assert reset between edges while a pulse is pending and state is FILL.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL midrst_det got=%b exp=0", detected);
        end
        checks++;
        if (match_cnt !== '0) begin
            failures++;
            $display("FAIL midrst_cnt got=%0d exp=0", match_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(stream[3-i], 1'b1);
            checks++;
            if (detected !== 1'b0) begin
                failures++;
                $display("FAIL midrst_post_det bit=%0d got=%b exp=0", i + 1, detected);
            end
        end
        load_cfg(8'b0000_0101, LEN_W'(4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(stream[3-i], 1'b1);
            checks++;
            if (detected !== (i == 3)) begin
                failures++;
                $display("FAIL midrst_reload_det bit=%0d got=%b exp=%b", i + 1, detected, (i == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_load_priority();
        test_len1_saturate();
        test_clamp();
        test_len0();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
